// File: rtl/ice40_uart_pkg.sv
// Shared types for the board UART transmit path.
// Holds the byte type, TX FSM state encoding and strobe width.
package ice40_uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        HOLD
    } tx_state_e;

    localparam int unsigned TX_STROBE_CYCLES = 1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with power-of-two depth, wrapping pointers and an occupancy count.
// A push while full is accepted only when a pop happens on the same edge.
module sync_byte_fifo
    import ice40_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  byte_t                  wr_data,
    input  logic                   rd_en,
    output byte_t                  rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    byte_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only written slots are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == FULL_LEVEL);
    assign empty   = (count == '0);
    assign level   = count;

endmodule

// File: rtl/uart_tx_fifo_sender.sv
// Buffers user bytes and strobes them onto the board TX pins under txready flow control.
// Define TX_FIFO_STATS_EN to add saturating sent/dropped byte counters.
module uart_tx_fifo_sender
    import ice40_uart_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned HOLD_TIMEOUT = 8
) (
    input  logic                   hz100,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    input  logic                   txready,
    output logic [7:0]             txdata,
    output logic                   txclk,
    output logic [15:0]            sent_cnt,
    output logic [15:0]            drop_cnt
);

    localparam int unsigned TW = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(HOLD_TIMEOUT - 1);

    tx_state_e     state;
    logic [TW-1:0] timer;
    logic          rd_en;
    byte_t         head;

    assign rd_en = (state == IDLE) && !empty && txready;

    sync_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (hz100),
        .rst     (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // Pop loads txdata on entry to STROBE; txclk is registered out of STROBE.
    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            timer  <= '0;
            txdata <= 8'h00;
            txclk  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    txclk <= 1'b0;
                    if (rd_en) begin
                        txdata <= head;
                        state  <= STROBE;
                    end
                end
                STROBE: begin
                    txclk <= 1'b1;
                    timer <= '0;
                    state <= HOLD;
                end
                HOLD: begin
                    txclk <= 1'b0;
                    if (!txready || timer == TIMER_LAST) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    txclk <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TX_FIFO_STATS_EN
    logic [15:0] sent_q;
    logic [15:0] drop_q;
    logic        drop_evt;

    assign drop_evt = wr_en && full && !rd_en;

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            sent_q <= '0;
            drop_q <= '0;
        end else begin
            if (state == STROBE) sent_q <= sat_inc16(sent_q);
            if (drop_evt)        drop_q <= sat_inc16(drop_q);
        end
    end

    assign sent_cnt = sent_q;
    assign drop_cnt = drop_q;
`else
    assign sent_cnt = 16'h0000;
    assign drop_cnt = 16'h0000;
`endif

endmodule
